mem_write_tracer: RTL and testbench

//  Passive monitor on the DA_VINCI memory bus: ADDR, MEM_DATA_IN, READ and WRITE.

---
 rtl/mem_write_tracer_pkg.sv | 24 ++
 rtl/mem_write_tracer_trace_fifo.sv | 93 +++++++++
 rtl/mem_write_tracer.sv | 97 +++++++++
 tb/tb_mem_write_tracer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_write_tracer_pkg.sv
// Shared defaults and helpers for the memory write tracer.
// Bus widths mirror the DA_VINCI project address/data limits.
package mem_write_tracer_pkg;

    localparam int DEF_ADDR_W = 26;
    localparam int DEF_DATA_W = 32;
    localparam int TRACE_DEPTH = 16;
    localparam int TRACE_REC_W = DEF_ADDR_W + DEF_DATA_W;
    localparam int DROP_W = 16;

    localparam logic [DEF_ADDR_W-1:0] DEF_WIN_BASE  = 26'h100_0000;
    localparam logic [DEF_ADDR_W-1:0] DEF_WIN_LIMIT = 26'h100_000F;

    function automatic logic [DROP_W-1:0] sat_inc16(input logic [DROP_W-1:0] v);
        logic [DROP_W-1:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_write_tracer_trace_fifo.sv
// Synchronous FIFO with a registered head stage; occupancy is tracked by a level
// counter so a full FIFO can accept a push in the same cycle as a pop.
module trace_fifo #(
    parameter int W     = 58,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [LVL_W-1:0] remain_s;
    logic [W-1:0]     dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             pop_ok_s, push_ok_s;

    // Pointer/level update and next head selection.
    always_comb begin
        pop_ok_s  = pop && valid_q;
        push_ok_s = push && ((level_q != LVL_W'(DEPTH)) || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + {{(LVL_W-1){1'b0}}, 1'b1};
            2'b01:   level_d = level_q - {{(LVL_W-1){1'b0}}, 1'b1};
            default: level_d = level_q;
        endcase
        // A record pushed this cycle becomes visible one edge later: no bypass.
        remain_s = level_q - {{(LVL_W-1){1'b0}}, pop_ok_s};
        valid_d  = (remain_s != {LVL_W{1'b0}});
        if (valid_d) begin
            dout_d = mem_q[rd_ptr_d];
        end else begin
            dout_d = {W{1'b0}};
        end
    end

    // Record storage (not reset; occupancy is governed by the level counter).
    always_ff @(posedge clk) begin
        if (push_ok_s && !srst) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointer, level and head registers.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            dout_q   <= {W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign level      = level_q;
    assign full       = (level_q == LVL_W'(DEPTH));
    assign empty      = (level_q == {LVL_W{1'b0}});

endmodule

// File: rtl/mem_write_tracer.sv
// Passive tracer: captures the rising edge of each in-window memory write strobe
// into a FIFO drained over valid/ready; counts drops and flags bus protocol errors.
module mem_write_tracer
    import mem_write_tracer_pkg::*;
#(
    parameter int                 ADDR_W    = DEF_ADDR_W,
    parameter int                 DATA_W    = DEF_DATA_W,
    parameter int                 DEPTH     = TRACE_DEPTH,
    parameter logic [ADDR_W-1:0]  WIN_BASE  = DEF_WIN_BASE,
    parameter logic [ADDR_W-1:0]  WIN_LIMIT = DEF_WIN_LIMIT
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDR_W-1:0]        ADDR,
    input  logic [DATA_W-1:0]        DATA,
    input  logic                     READ,
    input  logic                     WRITE,
    input  logic                     ENABLE,
    input  logic                     CLEAR,
    output logic                     TRC_VALID,
    input  logic                     TRC_READY,
    output logic [ADDR_W-1:0]        TRC_ADDR,
    output logic [DATA_W-1:0]        TRC_DATA,
    output logic [$clog2(DEPTH):0]   TRC_LEVEL,
    output logic [15:0]              DROP_CNT,
    output logic                     OVERFLOW,
    output logic                     PROTO_ERR
);

    localparam int REC_W = ADDR_W + DATA_W;

    logic              srst_s;
    logic              wr_q, wr_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic              overflow_q, overflow_d;
    logic              proto_err_q, proto_err_d;
    logic              in_win_s, hit_s, pop_s, push_s, drop_s;
    logic              fifo_full_s, fifo_empty_s;
    logic [REC_W-1:0]  fifo_dout_s;

    assign srst_s = RST || CLEAR;

    // Strobe detect, window compare, push/drop decision and sticky flags.
    always_comb begin
        wr_d     = WRITE;
        in_win_s = (ADDR >= WIN_BASE) && (ADDR <= WIN_LIMIT);
        hit_s    = ENABLE && WRITE && !wr_q && !READ && in_win_s;
        pop_s    = TRC_VALID && TRC_READY && !fifo_empty_s;
        push_s   = hit_s && (!fifo_full_s || pop_s);
        drop_s   = hit_s && fifo_full_s && !pop_s;
        if (drop_s) begin
            drop_cnt_d = sat_inc16(drop_cnt_q);
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
        overflow_d  = overflow_q || drop_s;
        proto_err_d = proto_err_q || (READ && WRITE);
    end

    // Strobe history, drop counter and sticky flag registers.
    always_ff @(posedge CLK) begin
        if (srst_s) begin
            wr_q        <= 1'b0;
            drop_cnt_q  <= 16'h0000;
            overflow_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            drop_cnt_q  <= drop_cnt_d;
            overflow_q  <= overflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk        (CLK),
        .srst       (srst_s),
        .push       (push_s),
        .pop        (pop_s),
        .din        ({ADDR, DATA}),
        .dout       (fifo_dout_s),
        .dout_valid (TRC_VALID),
        .level      (TRC_LEVEL),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    assign TRC_ADDR  = fifo_dout_s[REC_W-1:DATA_W];
    assign TRC_DATA  = fifo_dout_s[DATA_W-1:0];
    assign DROP_CNT  = drop_cnt_q;
    assign OVERFLOW  = overflow_q;
    assign PROTO_ERR = proto_err_q;

endmodule

// File: tb/tb_mem_write_tracer.sv
// Scoreboard bench for mem_write_tracer: a reference model queues expected
// records; a monitor pops and compares on every handshake.
module tb_mem_write_tracer;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam logic [AW-1:0] WB = 26'h100_0000;
    localparam logic [AW-1:0] WL = 26'h100_000F;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [AW-1:0] ADDR = '0;
    logic [DW-1:0] DATA = '0;
    logic          READ = 1'b0, WRITE = 1'b0, ENABLE = 1'b0, CLEAR = 1'b0;
    logic          TRC_VALID, TRC_READY = 1'b0;
    logic [AW-1:0] TRC_ADDR;
    logic [DW-1:0] TRC_DATA;
    logic [4:0]    TRC_LEVEL;
    logic [15:0]   DROP_CNT;
    logic          OVERFLOW, PROTO_ERR;

    int errors = 0;
    int checks = 0;

    logic [AW+DW-1:0] exp_q[$];
    int   m_level = 0;
    int   m_drop  = 0;
    bit   m_ovf   = 0;
    bit   m_perr  = 0;
    bit   m_prev  = 0;

    mem_write_tracer dut (
        .CLK(CLK), .RST(RST), .ADDR(ADDR), .DATA(DATA), .READ(READ), .WRITE(WRITE),
        .ENABLE(ENABLE), .CLEAR(CLEAR), .TRC_VALID(TRC_VALID), .TRC_READY(TRC_READY),
        .TRC_ADDR(TRC_ADDR), .TRC_DATA(TRC_DATA), .TRC_LEVEL(TRC_LEVEL),
        .DROP_CNT(DROP_CNT), .OVERFLOW(OVERFLOW), .PROTO_ERR(PROTO_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: compares state left by the last edge, then predicts the next edge.
    always @(negedge CLK) begin
        bit hit;
        bit pop;
        chk("level", 64'(TRC_LEVEL), 64'(m_level));
        chk("drop_cnt", 64'(DROP_CNT), 64'(m_drop));
        chk("overflow", 64'(OVERFLOW), 64'(m_ovf));
        chk("proto_err", 64'(PROTO_ERR), 64'(m_perr));
        if (m_level == 0) chk("valid_when_empty", 64'(TRC_VALID), 64'd0);
        if (RST || CLEAR) begin
            m_level = 0; m_drop = 0; m_ovf = 0; m_perr = 0; m_prev = 0;
            exp_q.delete();
        end else begin
            hit = ENABLE && WRITE && !m_prev && !READ && (ADDR >= WB) && (ADDR <= WL);
            pop = TRC_VALID && TRC_READY;
            if (READ && WRITE) m_perr = 1;
            if (hit) begin
                if (m_level < 16 || pop) begin
                    exp_q.push_back({ADDR, DATA});
                    m_level++;
                end else begin
                    if (m_drop < 16'hFFFF) m_drop++;
                    m_ovf = 1;
                end
            end
            if (pop) m_level--;
            m_prev = WRITE;
        end
    end

    // Monitor: every accepted head record must match the oldest expected record.
    always @(negedge CLK) begin
        logic [AW+DW-1:0] e;
        if (!RST && !CLEAR && TRC_VALID && TRC_READY) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_record", 64'(TRC_ADDR), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("rec_addr", 64'(TRC_ADDR), 64'(e[AW+DW-1:DW]));
                chk("rec_data", 64'(TRC_DATA), 64'(e[DW-1:0]));
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic en, input logic wr, input logic rd,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rdy);
        ENABLE = en; WRITE = wr; READ = rd; ADDR = a; DATA = d; TRC_READY = rdy;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        WRITE = 1'b0; READ = 1'b0; TRC_READY = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (TRC_LEVEL == 5'd0 && !TRC_VALID) begin
                done = 1;
                break;
            end
        end
        chk("drain_done", 64'(done), 64'd1);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        step(); step();
        RST = 1'b0;
        chk("rst_valid", 64'(TRC_VALID), 64'd0);
        chk("rst_addr", 64'(TRC_ADDR), 64'd0);
        chk("rst_data", 64'(TRC_DATA), 64'd0);

        // 1: single write, ready high, two-edge latency, one-cycle valid pulse.
        set_in(1, 1, 0, 26'h100_0003, 32'h0000_000D, 1);
        step();
        chk("t1_valid_n1", 64'(TRC_VALID), 64'd0);
        chk("t1_level_n1", 64'(TRC_LEVEL), 64'd1);
        WRITE = 1'b0;
        step();
        chk("t1_valid_n2", 64'(TRC_VALID), 64'd1);
        chk("t1_addr", 64'(TRC_ADDR), 64'h100_0003);
        chk("t1_data", 64'(TRC_DATA), 64'h0000_000D);
        step();
        chk("t1_valid_n3", 64'(TRC_VALID), 64'd0);

        // 2: write held five cycles yields one record.
        set_in(1, 1, 0, 26'h100_0000, 32'hCAFE_0001, 0);
        repeat (5) step();
        chk("t2_level", 64'(TRC_LEVEL), 64'd1);
        WRITE = 1'b0;
        step();
        chk("t2_level_after", 64'(TRC_LEVEL), 64'd1);
        drain();

        // 3: just outside the window on both sides.
        set_in(1, 1, 0, 26'h0FF_FFFF, 32'h1111_1111, 1); step();
        WRITE = 1'b0; step();
        set_in(1, 1, 0, 26'h100_0010, 32'h2222_2222, 1); step();
        WRITE = 1'b0; step(); step();
        chk("t3_level", 64'(TRC_LEVEL), 64'd0);
        chk("t3_drop", 64'(DROP_CNT), 64'd0);

        // 4: 18 strobes into a stalled consumer.
        for (int i = 0; i < 18; i++) begin
            set_in(1, 1, 0, WB + AW'(i % 16), $urandom, 0); step();
            WRITE = 1'b0; step();
        end
        chk("t4_level", 64'(TRC_LEVEL), 64'd16);
        chk("t4_drop", 64'(DROP_CNT), 64'd2);
        chk("t4_ovf", 64'(OVERFLOW), 64'd1);

        // 5: full FIFO, strobe coincides with a pop.
        set_in(1, 1, 0, 26'h100_0005, 32'h5555_AAAA, 1); step();
        chk("t5_level", 64'(TRC_LEVEL), 64'd16);
        chk("t5_drop", 64'(DROP_CNT), 64'd2);
        set_in(1, 0, 0, 26'h0, 32'h0, 0); step();
        drain();

        // 6: read+write collision, then reset with records queued.
        set_in(1, 1, 1, 26'h100_0001, 32'h6666_6666, 0); step();
        chk("t6_perr", 64'(PROTO_ERR), 64'd1);
        chk("t6_level", 64'(TRC_LEVEL), 64'd0);
        set_in(1, 0, 0, 26'h0, 32'h0, 0); step();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 1, 0, WB + AW'(i), $urandom, 0); step();
            WRITE = 1'b0; step();
        end
        chk("t6_level3", 64'(TRC_LEVEL), 64'd3);
        RST = 1'b1; step();
        RST = 1'b0;
        chk("t6_rst_valid", 64'(TRC_VALID), 64'd0);
        chk("t6_rst_addr", 64'(TRC_ADDR), 64'd0);
        chk("t6_rst_data", 64'(TRC_DATA), 64'd0);
        chk("t6_rst_level", 64'(TRC_LEVEL), 64'd0);
        chk("t6_rst_drop", 64'(DROP_CNT), 64'd0);
        chk("t6_rst_ovf", 64'(OVERFLOW), 64'd0);
        chk("t6_rst_perr", 64'(PROTO_ERR), 64'd0);

        // Random traffic around the window edges.
        for (int i = 0; i < 800; i++) begin
            ENABLE    = ($urandom_range(0, 7) != 0);
            WRITE     = ($urandom_range(0, 1) != 0);
            READ      = ($urandom_range(0, 24) == 0);
            ADDR      = 26'h0FF_FFF8 + AW'($urandom_range(0, 31));
            DATA      = $urandom;
            TRC_READY = (i % 200 < 100) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            CLEAR     = ($urandom_range(0, 149) == 0);
            step();
        end
        CLEAR = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
